// File: rtl/mine_placer.sv
// Board initialiser: clears every cell, then scatters NUM_MINES mines using a 16-bit LFSR,
// keeping the 3x3 block around the player's first selection free of mines.
module mine_placer #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int RW        = 3,
  parameter int CW        = 3,
  parameter int AW        = 6,
  parameter int NUM_MINES = 10,
  parameter int MAX_TRIES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   seed,
  input  logic [RW-1:0] safe_row,
  input  logic [CW-1:0] safe_col,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_wdata,
  input  logic          mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   mines_placed,
  output logic [2:0]    dbg_state
);

  localparam int          CELLS     = ROWS * COLS;
  localparam int          TW        = $clog2(MAX_TRIES + 1);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse
  // in the cycle after the last write (or abort), and busy covers every non-IDLE cycle.
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GEN, S_RD, S_CHK, S_WR, S_DONE
  } state_t;

  state_t         r_state, w_next;
  logic [15:0]    r_lfsr;
  logic [TW-1:0]  r_tries;
  logic [AW-1:0]  r_idx;
  logic [AW-1:0]  r_cand;
  logic [AW:0]    r_mines;
  logic           r_err;
  logic [RW-1:0]  r_safe_row;
  logic [CW-1:0]  r_safe_col;

  logic [15:0]    w_lfsr_next;
  logic [RW-1:0]  w_cand_row, w_dr;
  logic [CW-1:0]  w_cand_col, w_dc;
  logic [AW-1:0]  w_cand_addr;
  logic           w_reject, w_tries_max, w_last;

  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_cand_row  = r_lfsr[RW-1:0];
  assign w_cand_col  = r_lfsr[RW+CW-1:RW];
  assign w_dr        = (w_cand_row >= r_safe_row) ? w_cand_row - r_safe_row : r_safe_row - w_cand_row;
  assign w_dc        = (w_cand_col >= r_safe_col) ? w_cand_col - r_safe_col : r_safe_col - w_cand_col;
  assign w_cand_addr = AW'(int'(w_cand_row) * COLS + int'(w_cand_col));
  // Distances are plain unsigned differences, so the safe zone is clipped at board edges.
  assign w_reject    = (int'(w_cand_row) >= ROWS) || (int'(w_cand_col) >= COLS) ||
                       ((w_dr <= RW'(1)) && (w_dc <= CW'(1)));
  assign w_tries_max = (r_tries == TW'(MAX_TRIES));
  assign w_last      = (r_mines == (AW+1)'(NUM_MINES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = r_idx;
        if (r_idx == AW'(CELLS - 1)) w_next = S_GEN;
      end
      S_GEN: begin
        if (w_tries_max)   w_next = S_DONE;
        else if (!w_reject) w_next = S_RD;
      end
      S_RD: begin
        mem_addr = r_cand;
        w_next   = S_CHK;
      end
      S_CHK: begin
        mem_addr = r_cand;
        w_next   = mem_rdata ? S_GEN : S_WR;
      end
      S_WR: begin
        mem_we    = 1'b1;
        mem_wdata = 1'b1;
        mem_addr  = r_cand;
        w_next    = w_last ? S_DONE : S_GEN;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr     <= LFSR_INIT;
      r_tries    <= '0;
      r_idx      <= '0;
      r_cand     <= '0;
      r_mines    <= '0;
      r_err      <= 1'b0;
      r_safe_row <= '0;
      r_safe_col <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_lfsr     <= (seed == 16'h0000) ? LFSR_INIT : seed;
          r_safe_row <= safe_row;
          r_safe_col <= safe_col;
          r_err      <= 1'b0;
          r_mines    <= '0;
          r_tries    <= '0;
          r_idx      <= '0;
        end
        S_CLEAR: r_idx <= r_idx + AW'(1);
        S_GEN: begin
          if (w_tries_max) begin
            r_err <= 1'b1;
          end else begin
            r_lfsr  <= w_lfsr_next;
            r_tries <= r_tries + TW'(1);
            if (!w_reject) r_cand <= w_cand_addr;
          end
        end
        S_WR:    r_mines <= r_mines + (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign err          = r_err;
  assign mines_placed = r_mines;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: two instances (10 mines and an impossible 56 mines) with
// registered-read board models, checked against an arithmetic placement model.
module tb_mine_placer;

  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          a_start = 1'b0, a_mem_we, a_mem_wdata, a_mem_rdata = 1'b0;
  logic          a_busy, a_done, a_err;
  logic [15:0]   a_seed = '0;
  logic [2:0]    a_safe_row = '0, a_safe_col = '0, a_dbg;
  logic [AW-1:0] a_mem_addr;
  logic [AW:0]   a_mines;

  logic          b_start = 1'b0, b_mem_we, b_mem_wdata, b_mem_rdata = 1'b0;
  logic          b_busy, b_done, b_err;
  logic [15:0]   b_seed = '0;
  logic [2:0]    b_safe_row = '0, b_safe_col = '0, b_dbg;
  logic [AW-1:0] b_mem_addr;
  logic [AW:0]   b_mines;

  logic [63:0]   mem_a = '0, mem_b = '0, pre_pat = '0;
  logic          pre_load = 1'b0;

  logic          sel_big = 1'b0;
  logic          s_we, s_wdata, s_busy, s_done, s_err;
  logic [AW-1:0] s_addr;
  logic [AW:0]   s_mines;
  logic [63:0]   s_mem;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];
  logic [AW-1:0] seq0[$];
  int tests = 0, fails = 0;
  int clr_ok, done_cnt, done_cyc, m_err, m_placed, cnt;
  logic done_err;
  logic [AW:0] done_mines;

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  mine_placer dut_a (
    .clk(clk), .rst(rst), .start(a_start), .seed(a_seed),
    .safe_row(a_safe_row), .safe_col(a_safe_col),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .busy(a_busy), .done(a_done), .err(a_err), .mines_placed(a_mines), .dbg_state(a_dbg)
  );

  mine_placer #(.NUM_MINES(56)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .seed(b_seed),
    .safe_row(b_safe_row), .safe_col(b_safe_col),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .done(b_done), .err(b_err), .mines_placed(b_mines), .dbg_state(b_dbg)
  );

  always @(posedge clk) begin
    if (pre_load) mem_a <= pre_pat;
    else if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    a_mem_rdata <= mem_a[a_mem_addr];
    if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    b_mem_rdata <= mem_b[b_mem_addr];
  end

  always_comb begin
    s_we    = sel_big ? b_mem_we    : a_mem_we;
    s_wdata = sel_big ? b_mem_wdata : a_mem_wdata;
    s_addr  = sel_big ? b_mem_addr  : a_mem_addr;
    s_busy  = sel_big ? b_busy      : a_busy;
    s_done  = sel_big ? b_done      : a_done;
    s_err   = sel_big ? b_err       : a_err;
    s_mines = sel_big ? b_mines     : a_mines;
    s_mem   = sel_big ? mem_b       : mem_a;
  end

  // ---------------- scoreboard / reference model ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Placement rules applied directly: draw cells from the LFSR stream, skip the
  // safe neighbourhood and occupied cells, give up once the try budget is spent.
  function automatic void model(input logic [15:0] sd, input int sr, input int sc,
                                input int nm, input int mt, output int err_o, output int placed);
    logic [15:0] lf;
    bit   [63:0] board;
    int tries, r, c, dr, dc;
    lf = (sd == 16'h0000) ? 16'hACE1 : sd;
    board = '0; tries = 0; placed = 0; err_o = 0;
    exp_q.delete();
    while (placed < nm) begin
      if (tries == mt) begin
        err_o = 1;
        break;
      end
      r = int'(lf) % 8;
      c = (int'(lf) / 8) % 8;
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
      tries++;
      dr = (r > sr) ? r - sr : sr - r;
      dc = (c > sc) ? c - sc : sc - c;
      if (dr <= 1 && dc <= 1) continue;
      if (board[r*8+c]) continue;
      board[r*8+c] = 1'b1;
      exp_q.push_back(AW'(r*8+c));
      placed++;
    end
  endfunction

  function automatic int near_ones(input logic [63:0] m, input int sr, input int sc);
    int n = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if ((r - sr) <= 1 && (sr - r) <= 1 && (c - sc) <= 1 && (sc - c) <= 1 && m[r*8+c]) n++;
    return n;
  endfunction

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input bit big, input logic [15:0] sd, input int r, input int c);
    sel_big = big;
    @(negedge clk);
    if (big) begin
      b_seed = sd; b_safe_row = 3'(r); b_safe_col = 3'(c); b_start = 1'b1;
    end else begin
      a_seed = sd; a_safe_row = 3'(r); a_safe_col = 3'(c); a_start = 1'b1;
    end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Called at the first negedge after start was accepted (cycle 1).
  task automatic watch_run(input int glitch_cyc);
    got_q.delete();
    clr_ok = 0; done_cnt = 0; done_cyc = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      if (cyc == 1) begin
        check("start_err_clr", s_err, 0);
        check("start_cnt_clr", s_mines, 0);
        check("start_busy", s_busy, 1);
      end
      if (cyc <= 64) begin
        if (s_we === 1'b1 && s_wdata === 1'b0 && s_addr === AW'(cyc - 1)) clr_ok++;
      end else if (s_we && s_wdata) begin
        got_q.push_back(s_addr);
      end
      if (glitch_cyc != 0 && cyc == glitch_cyc) begin
        a_seed = 16'h5A5A; a_safe_row = 3'd7; a_safe_col = 3'd7; a_start = 1'b1;
      end else begin
        a_start = 1'b0;
      end
      if (s_done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = s_err;
        done_mines = s_mines;
        break;
      end
      @(negedge clk);
    end
    a_start = 1'b0;
    check("clear_seq", clr_ok, 64);
    check("done_seen", done_cnt, 1);
    @(negedge clk);
    check("done_one_cycle", s_done, 0);
    check("idle_after_done", s_busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // 1: asynchronous reset mid-clock, then idle with start low
    #3 rst = 1'b0;
    #1;
    check("rst_addr", a_mem_addr, 0);
    check("rst_we", a_mem_we, 0);
    check("rst_wdata", a_mem_wdata, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    check("rst_mines", a_mines, 0);
    check("rst_state", a_dbg, 0);
    check("rst_busy_b", b_busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_mem_we !== 1'b0 || a_busy !== 1'b0) cnt++;
    end
    check("idle_quiet", cnt, 0);

    // 2: default run, seed 1, safe corner
    do_start(0, 16'h0001, 0, 0);
    watch_run(0);
    model(16'h0001, 0, 0, 10, 1024, m_err, m_placed);
    check("t2_ones", $countones(mem_a), 10);
    check("t2_cell00", mem_a[0], 0);
    check("t2_cell01", mem_a[1], 0);
    check("t2_cell10", mem_a[8], 0);
    check("t2_cell11", mem_a[9], 0);
    check("t2_mines", done_mines, 10);
    check("t2_err", done_err, 0);
    check("t2_latency", (done_cyc >= 105), 1);
    compare_writes("t2_wr");

    // 3: seed 0 behaves as seed ACE1
    do_start(0, 16'h0000, 3, 3);
    watch_run(0);
    seq0 = got_q;
    model(16'hACE1, 3, 3, 10, 1024, m_err, m_placed);
    compare_writes("t3_wr0");
    check("t3_block0", near_ones(mem_a, 3, 3), 0);
    do_start(0, 16'hACE1, 3, 3);
    watch_run(0);
    check("t3_same_len", got_q.size(), seq0.size());
    while (got_q.size() > 0 && seq0.size() > 0) check("t3_same", got_q.pop_front(), seq0.pop_front());
    check("t3_block1", near_ones(mem_a, 3, 3), 0);

    // 4: board full of stale mines is fully cleared first; random seeds and safe cells
    for (int k = 0; k < 3; k++) begin
      logic [15:0] sd;
      int sr, sc;
      @(negedge clk);
      pre_pat = {$urandom, $urandom};
      pre_load = 1'b1;
      @(negedge clk);
      pre_load = 1'b0;
      sd = 16'($urandom);
      sr = $urandom_range(0, 7);
      sc = $urandom_range(0, 7);
      do_start(0, sd, sr, sc);
      watch_run(0);
      model(sd, sr, sc, 10, 1024, m_err, m_placed);
      check("t4_ones", $countones(mem_a), 10);
      check("t4_block", near_ones(mem_a, sr, sc), 0);
      check("t4_mines", done_mines, 10);
      compare_writes("t4_wr");
    end

    // 5: impossible mine count aborts after the try budget
    do_start(1, 16'hBEEF, 4, 4);
    watch_run(0);
    model(16'hBEEF, 4, 4, 56, 1024, m_err, m_placed);
    check("t5_err", done_err, m_err);
    check("t5_mines", done_mines, 55);
    check("t5_ones", $countones(mem_b), 55);
    compare_writes("t5_wr");
    repeat (5) @(negedge clk);
    check("t5_err_sticky", b_err, 1);
    check("t5_mines_hold", b_mines, 55);
    do_start(1, 16'h1F2E, 4, 4);
    watch_run(0);
    check("t5_err_again", done_err, 1);

    // 6: start during CLEAR is ignored; reset during GEN; then a clean run
    do_start(0, 16'h1357, 2, 5);
    watch_run(10);
    model(16'h1357, 2, 5, 10, 1024, m_err, m_placed);
    compare_writes("t6_glitch_wr");
    do_start(0, 16'h2468, 6, 1);
    repeat (64) @(negedge clk);
    check("t6_gen_busy", a_busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_busy", a_busy, 0);
    check("t6_rst_we", a_mem_we, 0);
    check("t6_rst_state", a_dbg, 0);
    @(negedge clk);
    rst = 1'b1;
    do_start(0, 16'h2468, 6, 1);
    watch_run(0);
    model(16'h2468, 6, 1, 10, 1024, m_err, m_placed);
    check("t6_ones", $countones(mem_a), 10);
    compare_writes("t6_wr");

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
